// File: rtl/alu_control_sequencer_if.sv
// Control bundle between the hardwired sequencer and the Datapath:
// run control and IR feed in, bus/load strobes and status out.
interface alu_control_sequencer_if #(
    parameter int RSW  = 4,
    parameter int CNTW = 16
);
    logic            Start;
    logic            Stop;
    logic            MemReady;
    logic [31:0]     IR;

    logic            PCout;
    logic            Zhiout;
    logic            Zlowout;
    logic            MDRout;
    logic            MARin;
    logic            Zin;
    logic            PCin;
    logic            MDRin;
    logic            IRin;
    logic            Yin;
    logic            IncPC;
    logic            Read;
    logic            Rout;
    logic            Rin;
    logic [RSW-1:0]  Rsel;
    logic            ADD;
    logic            SUB;
    logic            AND;
    logic            OR;
    logic            Running;
    logic            Illegal;
    logic [CNTW-1:0] InstrCount;

    modport master (
        input  Start, Stop, MemReady, IR,
        output PCout, Zhiout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
               IncPC, Read, Rout, Rin, Rsel, ADD, SUB, AND, OR,
               Running, Illegal, InstrCount
    );

    modport slave (
        output Start, Stop, MemReady, IR,
        input  PCout, Zhiout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
               IncPC, Read, Rout, Rin, Rsel, ADD, SUB, AND, OR,
               Running, Illegal, InstrCount
    );
endinterface

// File: rtl/alu_control_sequencer.sv
// Hardwired control unit: fetch (T0-T2) then execute (T3-T5) for
// register-register ALU instructions, with run control and an instruction counter.
module alu_control_sequencer #(
    parameter int OPW  = 5,
    parameter int RSW  = 4,
    parameter int CNTW = 16
) (
    input  logic                    Clock,
    input  logic                    Clear,
    alu_control_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
    } state_t;

    localparam int ALU_OPS = 4;
    localparam logic [OPW-1:0] OPC_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OPC_NOP  = OPW'(5'b11010);
    localparam logic [OPW-1:0] OPC_HALT = OPW'(5'b11011);

    state_t state_reg, state_next;

    logic [OPW-1:0]     ir_op;
    logic [RSW-1:0]     ir_ra, ir_rb, ir_rc;
    logic [ALU_OPS-1:0] alu_hit;
    logic [ALU_OPS-1:0] op_sel_reg;
    logic [RSW-1:0]     ra_reg, rc_reg;
    logic [CNTW-1:0]    count_reg;
    logic               unused_ir_bits;

    logic pc_out, zlow_out, mdr_out, mar_in, z_in, pc_in, mdr_in, ir_in, y_in;
    logic inc_pc, read, r_out, r_in, illegal, complete, count_en;
    logic [RSW-1:0]     rsel;
    logic [ALU_OPS-1:0] op_sel;

    assign ir_op = bus.IR[31 -: OPW];
    assign ir_ra = bus.IR[31-OPW -: RSW];
    assign ir_rb = bus.IR[31-OPW-RSW -: RSW];
    assign ir_rc = bus.IR[31-OPW-2*RSW -: RSW];
    assign unused_ir_bits = ^bus.IR[31-OPW-3*RSW:0];

    // ALU opcodes are consecutive from ADD; bit order is ADD, SUB, AND, OR.
    genvar gi;
    generate
        for (gi = 0; gi < ALU_OPS; gi = gi + 1) begin : g_alu_dec
            assign alu_hit[gi] = (ir_op == OPC_ADD + OPW'(gi));
        end
    endgenerate

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_reg  <= S_IDLE;
            count_reg  <= '0;
            op_sel_reg <= '0;
            ra_reg     <= '0;
            rc_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (count_en) begin
                count_reg <= count_reg + CNTW'(1);
            end
            // IR is only guaranteed in T3; keep what T4/T5 need.
            if (state_reg == S_T3) begin
                op_sel_reg <= alu_hit;
                ra_reg     <= ir_ra;
                rc_reg     <= ir_rc;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_out     = 1'b0;
        zlow_out   = 1'b0;
        mdr_out    = 1'b0;
        mar_in     = 1'b0;
        z_in       = 1'b0;
        pc_in      = 1'b0;
        mdr_in     = 1'b0;
        ir_in      = 1'b0;
        y_in       = 1'b0;
        inc_pc     = 1'b0;
        read       = 1'b0;
        r_out      = 1'b0;
        r_in       = 1'b0;
        rsel       = '0;
        op_sel     = '0;
        illegal    = 1'b0;
        complete   = 1'b0;
        count_en   = 1'b0;
        case (state_reg)
            S_IDLE, S_HALT: begin
                if (bus.Start) begin
                    state_next = S_T0;
                end
            end
            S_T0: begin
                pc_out     = 1'b1;
                mar_in     = 1'b1;
                inc_pc     = 1'b1;
                z_in       = 1'b1;
                state_next = S_T1;
            end
            S_T1: begin
                read   = 1'b1;
                mdr_in = 1'b1;
                // PC takes the incremented value only on the cycle that leaves T1.
                if (bus.MemReady) begin
                    zlow_out   = 1'b1;
                    pc_in      = 1'b1;
                    state_next = S_T2;
                end
            end
            S_T2: begin
                mdr_out    = 1'b1;
                ir_in      = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                if (|alu_hit) begin
                    r_out      = 1'b1;
                    rsel       = ir_rb;
                    y_in       = 1'b1;
                    state_next = S_T4;
                end else if (ir_op == OPC_HALT) begin
                    complete   = 1'b1;
                    count_en   = 1'b1;
                    state_next = S_HALT;
                end else begin
                    complete = 1'b1;
                    count_en = (ir_op == OPC_NOP);
                    illegal  = (ir_op != OPC_NOP);
                end
            end
            S_T4: begin
                r_out      = 1'b1;
                rsel       = rc_reg;
                op_sel     = op_sel_reg;
                z_in       = 1'b1;
                state_next = S_T5;
            end
            S_T5: begin
                zlow_out = 1'b1;
                r_in     = 1'b1;
                rsel     = ra_reg;
                complete = 1'b1;
                count_en = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
        if (complete && (state_next != S_HALT)) begin
            state_next = bus.Stop ? S_IDLE : S_T0;
        end
    end

    assign bus.PCout      = pc_out;
    assign bus.Zhiout     = 1'b0;
    assign bus.Zlowout    = zlow_out;
    assign bus.MDRout     = mdr_out;
    assign bus.MARin      = mar_in;
    assign bus.Zin        = z_in;
    assign bus.PCin       = pc_in;
    assign bus.MDRin      = mdr_in;
    assign bus.IRin       = ir_in;
    assign bus.Yin        = y_in;
    assign bus.IncPC      = inc_pc;
    assign bus.Read       = read;
    assign bus.Rout       = r_out;
    assign bus.Rin        = r_in;
    assign bus.Rsel       = rsel;
    assign bus.ADD        = op_sel[0];
    assign bus.SUB        = op_sel[1];
    assign bus.AND        = op_sel[2];
    assign bus.OR         = op_sel[3];
    assign bus.Illegal    = illegal;
    assign bus.Running    = (state_reg != S_IDLE) && (state_reg != S_HALT);
    assign bus.InstrCount = count_reg;
endmodule
